alu_ex_stage: RTL and testbench

Execute-stage datapath block that consumes the 4-bit ALU control code from the ALU control decoder together with the ID/EX operands. It computes the ALU result and flags, then registers them with the pass-through memory/writeback controls into an EX/MEM output register. A valid/ready handshake supports stall (backpressure) and flush (branch squash). A counter tracks executed operations.

---
 rtl/alu_ex_stage.sv | 164 ++++++++++++++++
 tb/tb_alu_ex_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ex_stage.sv
// Execute stage: ALU with flags feeding an EX/MEM output register under a valid/ready handshake.
// Supports backpressure stalls, branch-squash flush, and counts every accepted op.
module alu_ex_stage #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_ctrl,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  input  logic [DATA_W-1:0]     store_data,
  input  logic [REG_ADDR_W-1:0] write_reg,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     result,
  output logic                  zero,
  output logic                  overflow,
  output logic                  illegal_op,
  output logic [DATA_W-1:0]     out_store_data,
  output logic [REG_ADDR_W-1:0] out_write_reg,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic [31:0]           op_count
);

  localparam int unsigned Msb = DATA_W - 1;

  localparam logic [3:0] CtrlAnd = 4'b0000;
  localparam logic [3:0] CtrlOr  = 4'b0001;
  localparam logic [3:0] CtrlAdd = 4'b0010;
  localparam logic [3:0] CtrlSub = 4'b0110;
  localparam logic [3:0] CtrlSlt = 4'b0111;
  localparam logic [3:0] CtrlNor = 4'b1100;

  logic [DATA_W-1:0]     sum, diff;
  logic                  add_ovf, sub_ovf;
  logic [DATA_W-1:0]     alu_res;
  logic                  alu_ovf, alu_ill;
  logic                  accept;

  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic                  zero_q, zero_d;
  logic                  ovf_q, ovf_d;
  logic                  ill_q, ill_d;
  logic [DATA_W-1:0]     store_q, store_d;
  logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
  logic                  rw_q, rw_d;
  logic                  mr_q, mr_d;
  logic                  mw_q, mw_d;
  logic [31:0]           count_q, count_d;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    sum     = op_a + op_b;
    diff    = op_a - op_b;
    add_ovf = (op_a[Msb] == op_b[Msb]) && (sum[Msb] != op_a[Msb]);
    sub_ovf = (op_a[Msb] != op_b[Msb]) && (diff[Msb] != op_a[Msb]);
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (alu_ctrl)
      CtrlAnd: alu_res = op_a & op_b;
      CtrlOr:  alu_res = op_a | op_b;
      CtrlAdd: begin
        alu_res = sum;
        alu_ovf = add_ovf;
      end
      CtrlSub: begin
        alu_res = diff;
        alu_ovf = sub_ovf;
      end
      // Overflow correction keeps the signed compare right at the extremes.
      CtrlSlt: alu_res = {{(DATA_W-1){1'b0}}, diff[Msb] ^ sub_ovf};
      CtrlNor: alu_res = ~(op_a | op_b);
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    store_d  = store_q;
    wreg_d   = wreg_q;
    rw_d     = rw_q;
    mr_d     = mr_q;
    mw_d     = mw_q;
    count_d  = count_q;
    if (flush || (valid_q && out_ready && !accept)) begin
      // Data fields keep their last value; only the side-effecting bits drop.
      valid_d = 1'b0;
      ill_d   = 1'b0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      result_d = alu_res;
      zero_d   = (alu_res == '0);
      ovf_d    = alu_ovf;
      ill_d    = alu_ill;
      store_d  = store_data;
      wreg_d   = write_reg;
      rw_d     = reg_write && !alu_ill;
      mr_d     = mem_read;
      mw_d     = mem_write && !alu_ill;
      count_d  = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      store_q  <= '0;
      wreg_q   <= '0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      store_q  <= store_d;
      wreg_q   <= wreg_d;
      rw_q     <= rw_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      count_q  <= count_d;
    end
  end

  assign out_valid      = valid_q;
  assign result         = result_q;
  assign zero           = zero_q;
  assign overflow       = ovf_q;
  assign illegal_op     = ill_q;
  assign out_store_data = store_q;
  assign out_write_reg  = wreg_q;
  assign out_reg_write  = rw_q;
  assign out_mem_read   = mr_q;
  assign out_mem_write  = mw_q;
  assign op_count       = count_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Self-checking bench for alu_ex_stage: vector table streamed through a scoreboard queue,
// then hand-written stall, flush, illegal-op and async-reset sequences.
module tb_alu_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a, op_b, store_data;
  logic [4:0]  write_reg;
  logic        reg_write, mem_read, mem_write, flush;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        zero, overflow, illegal_op;
  logic [31:0] out_store_data;
  logic [4:0]  out_write_reg;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic [31:0] op_count;

  always #5 clk = ~clk;

  alu_ex_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .store_data(store_data),
    .write_reg(write_reg), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow), .illegal_op(illegal_op),
    .out_store_data(out_store_data), .out_write_reg(out_write_reg),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .op_count(op_count)
  );

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a, b;
    logic        rw, mr, mw;
    logic [31:0] res;
    logic        z, ov, ill, erw, emr, emw;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        z, ov, ill, rw, mr, mw;
    logic [31:0] store;
    logic [4:0]  wreg;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_count = 0;
  vec_t        vecs[14];
  vec_t        vx, vy, vz, vi;
  exp_t        ex, ey;

  function automatic vec_t mk(logic [3:0] c, logic [31:0] a, logic [31:0] b, logic rw,
                              logic mr, logic mw, logic [31:0] res, logic z, logic ov,
                              logic ill, logic erw, logic emr, logic emw);
    vec_t v;
    v.ctrl = c; v.a = a; v.b = b; v.rw = rw; v.mr = mr; v.mw = mw;
    v.res = res; v.z = z; v.ov = ov; v.ill = ill; v.erw = erw; v.emr = emr; v.emw = emw;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
    end
  endtask

  function automatic exp_t to_exp(vec_t v, int idx);
    exp_t e;
    e.res = v.res; e.z = v.z; e.ov = v.ov; e.ill = v.ill;
    e.rw = v.erw; e.mr = v.emr; e.mw = v.emw;
    e.store = 32'hA500_0000 | 32'(idx);
    e.wreg = 5'(idx);
    return e;
  endfunction

  task automatic drive(vec_t v, int idx);
    in_valid   = 1'b1;
    alu_ctrl   = v.ctrl;
    op_a       = v.a;
    op_b       = v.b;
    reg_write  = v.rw;
    mem_read   = v.mr;
    mem_write  = v.mw;
    store_data = 32'hA500_0000 | 32'(idx);
    write_reg  = 5'(idx);
  endtask

  task automatic check_rec(string tag, exp_t e);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".result"}, result, e.res);
    check({tag, ".zero"}, 32'(zero), 32'(e.z));
    check({tag, ".overflow"}, 32'(overflow), 32'(e.ov));
    check({tag, ".illegal_op"}, 32'(illegal_op), 32'(e.ill));
    check({tag, ".reg_write"}, 32'(out_reg_write), 32'(e.rw));
    check({tag, ".mem_read"}, 32'(out_mem_read), 32'(e.mr));
    check({tag, ".mem_write"}, 32'(out_mem_write), 32'(e.mw));
    check({tag, ".store_data"}, out_store_data, e.store);
    check({tag, ".write_reg"}, 32'(out_write_reg), 32'(e.wreg));
  endtask

  task automatic check_pop(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty, got out_valid=%0b, expected a queued op", tag, out_valid);
    end else begin
      e = sb.pop_front();
      check_rec(tag, e);
      check({tag, ".op_count"}, op_count, exp_count);
    end
  endtask

  initial begin
    vecs[0]  = mk(4'b0010, 32'd5, 32'd7, 1, 0, 0, 32'd12, 0, 0, 0, 1, 0, 0);
    vecs[1]  = mk(4'b0110, 32'd3, 32'd3, 0, 0, 1, 32'd0, 1, 0, 0, 0, 0, 1);
    vecs[2]  = mk(4'b0111, 32'hFFFF_FFFF, 32'd1, 1, 0, 0, 32'd1, 0, 0, 0, 1, 0, 0);
    vecs[3]  = mk(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 1, 0, 0, 32'd0, 1, 0, 0, 1, 0, 0);
    vecs[4]  = mk(4'b0010, 32'h7FFF_FFFF, 32'd1, 1, 0, 0, 32'h8000_0000, 0, 1, 0, 1, 0, 0);
    vecs[5]  = mk(4'b0110, 32'h8000_0000, 32'd1, 1, 0, 0, 32'h7FFF_FFFF, 0, 1, 0, 1, 0, 0);
    vecs[6]  = mk(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 1, 0, 32'hF000_F000, 0, 0, 0, 1, 1, 0);
    vecs[7]  = mk(4'b0001, 32'hF0F0_F0F0, 32'h0F0F_0000, 1, 0, 0, 32'hFFFF_F0F0, 0, 0, 0, 1, 0, 0);
    vecs[8]  = mk(4'b1100, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1, 0, 0, 32'd0, 1, 0, 0, 1, 0, 0);
    vecs[9]  = mk(4'b0010, 32'hFFFF_FFFF, 32'd1, 1, 0, 0, 32'd0, 1, 0, 0, 1, 0, 0);
    vecs[10] = mk(4'b0110, 32'd0, 32'd1, 1, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0);
    vecs[11] = mk(4'b0111, 32'h8000_0000, 32'd1, 1, 0, 0, 32'd1, 0, 0, 0, 1, 0, 0);
    vecs[12] = mk(4'b1111, 32'd5, 32'd7, 1, 1, 1, 32'd0, 1, 0, 1, 0, 1, 0);
    vecs[13] = mk(4'b0011, 32'd9, 32'd9, 1, 0, 1, 32'd0, 1, 0, 1, 0, 0, 0);

    rst_n = 1'b0; in_valid = 0; out_ready = 1; flush = 0; alu_ctrl = 0;
    op_a = 0; op_b = 0; store_data = 0; write_reg = 0;
    reg_write = 0; mem_read = 0; mem_write = 0;
    #12;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.result", result, 32'd0);
    check("reset.zero", 32'(zero), 32'd0);
    check("reset.op_count", op_count, 32'd0);
    rst_n = 1'b1;

    // Back-to-back stream with MEM always ready.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i], i + 1);
      sb.push_back(to_exp(vecs[i], i + 1));
      exp_count++;
      @(posedge clk); #1;
      check_pop($sformatf("vec%0d", i));
    end

    // Drain: valid and control bits drop, data holds.
    @(negedge clk);
    in_valid = 0;
    @(posedge clk); #1;
    check("drain.out_valid", 32'(out_valid), 32'd0);
    check("drain.illegal_op", 32'(illegal_op), 32'd0);
    check("drain.store_hold", out_store_data, 32'hA500_000E);
    check("drain.op_count", op_count, exp_count);

    // Backpressure: X held for 3 cycles while Y waits, then Y loads with no bubble.
    vx = mk(4'b0010, 32'd1, 32'd2, 1, 0, 0, 32'd3, 0, 0, 0, 1, 0, 0);
    vy = mk(4'b0110, 32'd10, 32'd4, 1, 1, 0, 32'd6, 0, 0, 0, 1, 1, 0);
    ex = to_exp(vx, 20);
    ey = to_exp(vy, 21);
    @(negedge clk);
    out_ready = 0;
    drive(vx, 20);
    sb.push_back(ex);
    exp_count++;
    @(posedge clk); #1;
    check_pop("bp_x");
    @(negedge clk);
    drive(vy, 21);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("stall%0d.in_ready", c), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check_rec($sformatf("stall%0d", c), ex);
      check($sformatf("stall%0d.op_count", c), op_count, exp_count);
      @(negedge clk);
    end
    out_ready = 1;
    #1;
    check("release.in_ready", 32'(in_ready), 32'd1);
    sb.push_back(ey);
    exp_count++;
    @(posedge clk); #1;
    check_pop("bp_y");

    // Flush with an incoming op while the held op is stalled.
    vz = mk(4'b0010, 32'd100, 32'd1, 1, 1, 1, 32'd0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    out_ready = 0;
    flush = 1;
    drive(vz, 22);
    @(posedge clk); #1;
    check("flush.out_valid", 32'(out_valid), 32'd0);
    check("flush.reg_write", 32'(out_reg_write), 32'd0);
    check("flush.mem_read", 32'(out_mem_read), 32'd0);
    check("flush.op_count", op_count, exp_count);
    check("flush.result_hold", result, 32'd6);

    // Illegal opcode, then async reset in mid-cycle.
    vi = mk(4'b1111, 32'd8, 32'd8, 1, 0, 1, 32'd0, 1, 0, 1, 0, 0, 0);
    @(negedge clk);
    flush = 0;
    out_ready = 1;
    drive(vi, 23);
    sb.push_back(to_exp(vi, 23));
    exp_count++;
    @(posedge clk); #1;
    check_pop("illegal");
    in_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("areset.out_valid", 32'(out_valid), 32'd0);
    check("areset.in_ready", 32'(in_ready), 32'd1);
    check("areset.result", result, 32'd0);
    check("areset.store_data", out_store_data, 32'd0);
    check("areset.op_count", op_count, 32'd0);
    check("areset.zero", 32'(zero), 32'd0);
    check("areset.illegal_op", 32'(illegal_op), 32'd0);
    check("areset.pending", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
